// File: rtl/camif_pkg.sv
// Shared definitions for the multi-camera interface: FSM state encoding,
// sensor power-up length, select pipeline depth and default parameters.
package camif_pkg;

  typedef enum logic [2:0] {
    SENSOR_RST,
    FIND_FRAME,
    FRAME_GAP,
    WAIT_FRAME,
    FIND_LINE,
    WAIT_LINE,
    READ
  } camif_state_t;

  localparam int SENSOR_RST_CYCLES = 5;
  localparam int SELECT_DELAY      = 2;

  localparam int DEF_LINE_PIXELS  = 640;
  localparam int DEF_FRAME_LINES  = 480;
  localparam int DEF_NUM_CHANNELS = 2;
  localparam int DEF_NUM_SELECT   = 6;
  localparam int DEF_START_LINE   = 5;
  localparam int DEF_KEEP_BITS    = 3;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/camif_line_counter.sv
// Column / channel / line position counters for the camera interface.
// Advances once per accepted pixel; column wraps into channel, channel
// wraps into line, line wraps to 0 after the last line of the frame.
module camif_line_counter
  import camif_pkg::*;
#(
  parameter int LINE_PIXELS  = DEF_LINE_PIXELS,
  parameter int FRAME_LINES  = DEF_FRAME_LINES,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
  input  logic                                 pixel_clock,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 advance,
  output logic [clog2_min1(LINE_PIXELS)-1:0]   col,
  output logic [clog2_min1(NUM_CHANNELS)-1:0]  chan,
  output logic [clog2_min1(FRAME_LINES)-1:0]   line_idx,
  output logic                                 last_line,
  output logic                                 line_end
);

  localparam int COL_W  = clog2_min1(LINE_PIXELS);
  localparam int CHAN_W = clog2_min1(NUM_CHANNELS);
  localparam int LINE_W = clog2_min1(FRAME_LINES);

  logic last_col;
  logic last_chan;

  assign last_col  = (col == COL_W'(LINE_PIXELS - 1));
  assign last_chan = (chan == CHAN_W'(NUM_CHANNELS - 1));
  assign last_line = (line_idx == LINE_W'(FRAME_LINES - 1));
  assign line_end  = advance && last_col && last_chan;

  // Position counters, cleared on abort, stepped on each accepted pixel.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      col      <= '0;
      chan     <= '0;
      line_idx <= '0;
    end else if (clear) begin
      col      <= '0;
      chan     <= '0;
      line_idx <= '0;
    end else if (advance) begin
      if (!last_col) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (!last_chan) begin
          chan <= chan + 1'b1;
        end else begin
          chan     <= '0;
          line_idx <= last_line ? '0 : line_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_camera_interface.sv
// Multi-camera sensor front end: sensor power-up reset, frame/line sync
// tracking, channel de-interleave, pixel quantisation and row-buffer select.
// Optional feature macro: CAMIF_SYNC_CHECK_EN enables short line / short
// frame detection with a sticky sync_error flag.
module multi_camera_interface
  import camif_pkg::*;
#(
  parameter int LINE_PIXELS  = DEF_LINE_PIXELS,
  parameter int FRAME_LINES  = DEF_FRAME_LINES,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int NUM_SELECT   = DEF_NUM_SELECT,
  parameter int START_LINE   = DEF_START_LINE,
  parameter int KEEP_BITS    = DEF_KEEP_BITS
) (
  input  logic                                pixel_clock,
  input  logic                                reset,
  input  logic                                frame_valid,
  input  logic                                line_valid,
  input  logic [7:0]                          pixel_data,
  output logic                                sensor_reset_n,
  output logic [NUM_CHANNELS-1:0]             chan_valid,
  output logic [7:0]                          data,
  output logic [clog2_min1(LINE_PIXELS)-1:0]  pixel_col,
  output logic [clog2_min1(FRAME_LINES)-1:0]  line_idx,
  output logic [clog2_min1(NUM_SELECT)-1:0]   select,
  output logic                                read_start,
  output logic                                frame_done,
  output logic                                sync_error
);

  localparam int CHAN_W = clog2_min1(NUM_CHANNELS);
  localparam int SEL_W  = clog2_min1(NUM_SELECT);
  localparam int RST_W  = clog2_min1(SENSOR_RST_CYCLES);
  localparam logic [7:0] KEEP_MASK = ~(8'hFF >> KEEP_BITS);

  camif_state_t       state;
  camif_state_t       state_next;
  logic [RST_W-1:0]   rst_cnt;
  logic [CHAN_W-1:0]  chan;
  logic               last_line;
  logic               line_end;
  logic               take;
  logic               sync_fault;
  logic [SEL_W-1:0]   select_cnt;
  logic [SEL_W-1:0]   select_pipe [SELECT_DELAY];

`ifdef CAMIF_SYNC_CHECK_EN
  logic frame_valid_q;
  logic in_frame;

  assign in_frame   = (state == FIND_LINE) || (state == WAIT_LINE) || (state == READ);
  assign sync_fault = (in_frame && !frame_valid && !last_line) ||
                      ((state == READ) && !line_valid);

  // Sticky sync error, cleared by the next rising edge of frame_valid.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      frame_valid_q <= 1'b0;
      sync_error    <= 1'b0;
    end else begin
      frame_valid_q <= frame_valid;
      if (sync_fault) begin
        sync_error <= 1'b1;
      end else if (frame_valid && !frame_valid_q) begin
        sync_error <= 1'b0;
      end
    end
  end
`else
  assign sync_fault = 1'b0;
  assign sync_error = 1'b0;
`endif

  // A pixel is accepted on the WAIT_LINE entry cycle and every READ cycle.
  assign take = !sync_fault &&
                (((state == WAIT_LINE) && line_valid) || (state == READ));

  camif_line_counter #(
    .LINE_PIXELS  (LINE_PIXELS),
    .FRAME_LINES  (FRAME_LINES),
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_line_counter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .clear       (sync_fault),
    .advance     (take),
    .col         (pixel_col),
    .chan        (chan),
    .line_idx    (line_idx),
    .last_line   (last_line),
    .line_end    (line_end)
  );

  // FSM state register and sensor power-up cycle counter.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state   <= SENSOR_RST;
      rst_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == SENSOR_RST) begin
        rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; line end and sync faults override the per-state step.
  // NOTE: state_next is assigned a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      SENSOR_RST: if (rst_cnt == RST_W'(SENSOR_RST_CYCLES - 1)) state_next = FIND_FRAME;
      FIND_FRAME: if (!frame_valid) state_next = FRAME_GAP;
      FRAME_GAP:  state_next = frame_valid ? FIND_FRAME : WAIT_FRAME;
      WAIT_FRAME: if (frame_valid) state_next = FIND_LINE;
      FIND_LINE:  if (!line_valid) state_next = WAIT_LINE;
      WAIT_LINE:  if (line_valid) state_next = READ;
      READ:       state_next = READ;
      default:    state_next = SENSOR_RST;
    endcase
    if (line_end) begin
      state_next = last_line ? FIND_FRAME : FIND_LINE;
    end
    if (sync_fault) begin
      state_next = FIND_FRAME;
    end
  end

  // Registered outputs: sensor reset, pixel data/channel, line pulses, select.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      sensor_reset_n <= 1'b0;
      chan_valid     <= '0;
      data           <= '0;
      read_start     <= 1'b0;
      frame_done     <= 1'b0;
      select_cnt     <= '0;
    end else begin
      sensor_reset_n <= (state_next != SENSOR_RST);
      chan_valid     <= take ? (NUM_CHANNELS'(1) << chan) : '0;
      if (take) begin
        data <= pixel_data & KEEP_MASK;
      end
      read_start <= line_end && (last_line || (int'(line_idx) >= START_LINE));
      frame_done <= line_end && last_line;
      if (sync_fault || (line_end && last_line)) begin
        select_cnt <= '0;
      end else if (line_end) begin
        select_cnt <= (select_cnt == SEL_W'(NUM_SELECT - 1)) ? '0 : select_cnt + 1'b1;
      end
    end
  end

  // Delay line aligning the select output with the downstream buffer write.
  // NOTE: this small pipeline is reset so select reads 0 straight out of
  // reset; a large storage array would normally be left unreset.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SELECT_DELAY; i++) select_pipe[i] <= '0;
    end else begin
      select_pipe[0] <= select_cnt;
      for (int i = 1; i < SELECT_DELAY; i++) select_pipe[i] <= select_pipe[i-1];
    end
  end

  assign select = select_pipe[SELECT_DELAY-1];

endmodule

// File: tb/tb_multi_camera_interface.sv
// Self-checking bench for multi_camera_interface (small geometry: 4 pixels x
// 2 channels, 3 lines, 2 selects, read_start from line 1). Pixels driven are
// pushed to a scoreboard queue and popped when chan_valid reports them.
// The short-line scenario is compiled only with CAMIF_SYNC_CHECK_EN.
module tb_multi_camera_interface;

  localparam int LP = 4;
  localparam int FL = 3;
  localparam int NC = 2;
  localparam int NS = 2;
  localparam int SL = 1;
  localparam int KB = 3;
  localparam logic [7:0] MASK = 8'hE0;

  logic       pixel_clock = 1'b0;
  logic       reset       = 1'b1;
  logic       frame_valid = 1'b0;
  logic       line_valid  = 1'b0;
  logic [7:0] pixel_data  = 8'h00;
  logic       sensor_reset_n;
  logic [1:0] chan_valid;
  logic [7:0] data;
  logic [1:0] pixel_col;
  logic [1:0] line_idx;
  logic [0:0] select;
  logic       read_start;
  logic       frame_done;
  logic       sync_error;

  typedef struct packed {
    logic [1:0] cv;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rs_cnt = 0;
  int   fd_cnt = 0;
  int   exp_rs = 0;
  int   exp_fd = 0;
  int   exp_sel = 0;

  multi_camera_interface #(
    .LINE_PIXELS  (LP),
    .FRAME_LINES  (FL),
    .NUM_CHANNELS (NC),
    .NUM_SELECT   (NS),
    .START_LINE   (SL),
    .KEEP_BITS    (KB)
  ) dut (
    .pixel_clock    (pixel_clock),
    .reset          (reset),
    .frame_valid    (frame_valid),
    .line_valid     (line_valid),
    .pixel_data     (pixel_data),
    .sensor_reset_n (sensor_reset_n),
    .chan_valid     (chan_valid),
    .data           (data),
    .pixel_col      (pixel_col),
    .line_idx       (line_idx),
    .select         (select),
    .read_start     (read_start),
    .frame_done     (frame_done),
    .sync_error     (sync_error)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counters and scoreboard pops, sampled mid-cycle.
  always @(negedge pixel_clock) begin
    if (!reset) begin
      if (read_start === 1'b1) rs_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (chan_valid !== 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_extra", 32'({chan_valid, data}), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("sb_px", 32'({chan_valid, data}), 32'(mon_e));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_srn"},  32'(sensor_reset_n), 32'(0));
    check({tag, "_cv"},   32'(chan_valid),     32'(0));
    check({tag, "_data"}, 32'(data),           32'(0));
    check({tag, "_rs"},   32'(read_start),     32'(0));
    check({tag, "_fd"},   32'(frame_done),     32'(0));
    check({tag, "_se"},   32'(sync_error),     32'(0));
    check({tag, "_sel"},  32'(select),         32'(0));
    check({tag, "_line"}, 32'(line_idx),       32'(0));
    check({tag, "_col"},  32'(pixel_col),      32'(0));
  endtask

  // Called at the negedge where reset is released; counts low cycles.
  task automatic measure_sensor_reset(input string tag);
    int n = 0;
    while (sensor_reset_n !== 1'b1 && n < 20) begin
      n++;
      @(negedge pixel_clock);
    end
    check(tag, 32'(n), 32'(5));
  endtask

  task automatic send_pixel(input int idx, input logic [7:0] px);
    exp_t e;
    line_valid = 1'b1;
    pixel_data = px;
    e.cv = (idx < LP) ? 2'b01 : 2'b10;
    e.d  = px & MASK;
    sb.push_back(e);
    @(negedge pixel_clock);
    if (idx == 0) begin
      check("lat_cv",   32'(chan_valid), 32'(2'b01));
      check("lat_data", 32'(data),       32'(px & MASK));
    end
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) send_pixel(i, 8'($urandom));
  endtask

  // Starts from FIND_FRAME: two-cycle frame gap, frame rise, line gap.
  task automatic frame_start();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    repeat (2) @(negedge pixel_clock);
    frame_valid = 1'b1;
    @(negedge pixel_clock);
    check("se_clear", 32'(sync_error), 32'(0));
    @(negedge pixel_clock);
  endtask

  task automatic send_line(input int ln, input logic [7:0] first_px);
    int old_sel;
    int new_sel;
    for (int i = 0; i < LP * NC; i++) begin
      send_pixel(i, (i == 0) ? first_px : 8'($urandom));
    end
    line_valid = 1'b0;
    old_sel = exp_sel;
    new_sel = (ln == FL - 1) ? 0 : (exp_sel + 1) % NS;
    if (ln >= SL || ln == FL - 1) exp_rs++;
    if (ln == FL - 1) exp_fd++;
    check("line_idx", 32'(line_idx),  32'((ln == FL - 1) ? 0 : ln + 1));
    check("col_wrap", 32'(pixel_col), 32'(0));
    check("sel_e1",   32'(select),    32'(old_sel));
    @(negedge pixel_clock);
    check("sel_e2",   32'(select),    32'(old_sel));
    check("rs_count", 32'(rs_cnt),    32'(exp_rs));
    check("fd_count", 32'(fd_cnt),    32'(exp_fd));
    check("sb_empty", 32'(sb.size()), 32'(0));
    @(negedge pixel_clock);
    check("sel_e3",   32'(select),    32'(new_sel));
    exp_sel = new_sel;
  endtask

  task automatic run_frame(input logic [7:0] first_px);
    frame_start();
    send_line(0, first_px);
    send_line(1, 8'hA5);
    send_line(2, 8'h1F);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge pixel_clock);
    check_reset_outputs("por");
    reset = 1'b0;
    measure_sensor_reset("srst_len");

    run_frame(8'hFF);
    check("se_clean", 32'(sync_error), 32'(0));

    // Reset in the middle of line 1 aborts without frame_done.
    frame_start();
    send_line(0, 8'h80);
    send_pixels(3);
    #2;
    reset       = 1'b1;
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    exp_sel     = 0;
    @(negedge pixel_clock);
    check("abort_sb", 32'(sb.size()), 32'(0));
    sb.delete();
    check_reset_outputs("mid");
    repeat (2) @(negedge pixel_clock);
    check("abort_fd", 32'(fd_cnt), 32'(exp_fd));
    reset = 1'b0;
    measure_sensor_reset("srst_again");
    run_frame(8'h7F);

`ifdef CAMIF_SYNC_CHECK_EN
    // Short line: line_valid drops at pixel 5.
    frame_start();
    send_pixels(5);
    line_valid = 1'b0;
    @(negedge pixel_clock);
    check("short_se",   32'(sync_error), 32'(1));
    check("short_cv",   32'(chan_valid), 32'(0));
    check("short_line", 32'(line_idx),   32'(0));
    check("short_col",  32'(pixel_col),  32'(0));
    @(negedge pixel_clock);
    check("short_rs",   32'(rs_cnt),     32'(exp_rs));
    check("short_sb",   32'(sb.size()),  32'(0));
    sb.delete();
    run_frame(8'hC3);
`endif

    check("total_fd", 32'(fd_cnt), 32'(exp_fd));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
